// File: rtl/axil_pkg.sv
// Shared types and helpers for the AXI4-Lite to register-file bridge.
package axil_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_EXEC = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_CAP  = 3'd4,
    RD_RESP = 3'd5
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Byte address to 32-bit register word index.
  function automatic logic [31:0] addr_to_index(input logic [63:0] byte_addr);
    return 32'(byte_addr >> 2);
  endfunction

endpackage

// File: rtl/axil_regfile_bridge.sv
// AXI4-Lite slave that turns single AW/W or AR transactions into one-cycle regfile accesses.
// Define AXIL_SLVERR_EN to answer out-of-range word indices with SLVERR instead of forwarding them.
module axil_regfile_bridge
  import axil_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 3
) (
  input  logic              ACLK,
  input  logic              ARSTn,
  input  logic [ADDR_W-1:0] AWADDR,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [DATA_W-1:0] WDATA,
  input  logic              WVALID,
  output logic              WREADY,
  output logic [1:0]        BRESP,
  output logic              BVALID,
  input  logic              BREADY,
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic [DATA_W-1:0] RDATA,
  output logic [1:0]        RRESP,
  output logic              RVALID,
  input  logic              RREADY,
  output logic [31:0]       reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_rw,
  input  logic [DATA_W-1:0] reg_rdata
);

  state_t            state;
  logic              aw_held;
  logic              w_held;
  logic [ADDR_W-1:0] awaddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              rd_err;

  logic              aw_hs;
  logic              w_hs;
  logic              ar_hs;
  logic              wr_go;
  logic              wr_err;
  logic              ar_err;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  // READY is gated by ARSTn so every READY reads 0 while reset is held.
  always_comb begin
    AWREADY = ARSTn && (state == IDLE) && !aw_held;
    WREADY  = ARSTn && (state == IDLE) && !w_held;
    ARREADY = ARSTn && (state == IDLE) && !aw_held && !w_held && !AWVALID && !WVALID;
  end

  assign aw_hs   = AWVALID && AWREADY;
  assign w_hs    = WVALID && WREADY;
  assign ar_hs   = ARVALID && ARREADY;
  assign wr_go   = (aw_held || aw_hs) && (w_held || w_hs);
  assign wr_addr = aw_hs ? AWADDR : awaddr_q;
  assign wr_data = w_hs ? WDATA : wdata_q;

`ifdef AXIL_SLVERR_EN
  function automatic logic out_of_range(input logic [ADDR_W-1:0] byte_addr);
    return (byte_addr >> 2) >= ADDR_W'(NUM_REGS);
  endfunction

  assign wr_err = out_of_range(wr_addr);
  assign ar_err = out_of_range(ARADDR);
`else
  assign wr_err = 1'b0;
  assign ar_err = 1'b0;
`endif

  always_ff @(posedge ACLK or negedge ARSTn) begin
    if (!ARSTn) begin
      state     <= IDLE;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      rd_err    <= 1'b0;
      reg_rw    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      BVALID    <= 1'b0;
      BRESP     <= RESP_OKAY;
      RVALID    <= 1'b0;
      RRESP     <= RESP_OKAY;
      RDATA     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (aw_hs) begin
            aw_held  <= 1'b1;
            awaddr_q <= AWADDR;
          end
          if (w_hs) begin
            w_held  <= 1'b1;
            wdata_q <= WDATA;
          end
          // Write wins: ARREADY is already low whenever a write is in flight.
          if (wr_go) begin
            state     <= WR_EXEC;
            reg_addr  <= addr_to_index(64'(wr_addr));
            reg_wdata <= wr_data;
            reg_rw    <= !wr_err;
            BRESP     <= wr_err ? RESP_SLVERR : RESP_OKAY;
          end else if (ar_hs) begin
            state    <= RD_REQ;
            reg_addr <= addr_to_index(64'(ARADDR));
            rd_err   <= ar_err;
          end
        end
        WR_EXEC: begin
          reg_rw  <= 1'b0;
          aw_held <= 1'b0;
          w_held  <= 1'b0;
          BVALID  <= 1'b1;
          state   <= WR_RESP;
        end
        WR_RESP: begin
          if (BREADY) begin
            BVALID <= 1'b0;
            state  <= IDLE;
          end
        end
        RD_REQ: state <= RD_CAP;
        RD_CAP: begin
          RDATA  <= rd_err ? '0 : reg_rdata;
          RRESP  <= rd_err ? RESP_SLVERR : RESP_OKAY;
          RVALID <= 1'b1;
          state  <= RD_RESP;
        end
        RD_RESP: begin
          if (RREADY) begin
            RVALID <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
